// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - weight/activation sequencer with credit flow control for the systolic MAC array
// Optional MAC_SEQ_SKEW_EN: diagonal per-lane activation skew and a longer flush.
module mac_seq_ctrl #(
  parameter int DW      = 8,
  parameter int WW      = 8,
  parameter int ROW     = 8,
  parameter int COLUMN  = 6,
  parameter int ARR_LAT = 9,
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          cfg_nvec,
  output logic                 busy,
  output logic                 done,
  input  logic [COLUMN*WW-1:0] wt_data,
  input  logic                 wt_valid,
  output logic                 wt_ready,
  input  logic [ROW*DW-1:0]    act_data,
  input  logic                 act_valid,
  output logic                 act_ready,
  output logic [COLUMN*WW-1:0] w,
  output logic [COLUMN-1:0]    w_en,
  output logic [ROW*DW-1:0]    mac_m_data,
  output logic                 mac_m_valid,
  output logic                 mac_m_first,
  output logic                 mac_m_last,
  output logic                 res_valid,
  output logic                 res_first,
  output logic                 res_last,
  input  logic                 res_pop
);

  localparam int WCW = $clog2(ROW) + 1;
  localparam logic [WCW-1:0] WLAST    = WCW'(ROW - 1);
  localparam logic [WCW-1:0] DLAST    = WCW'(ROW - 2);
  localparam logic [3:0]     CRED_MAX = 4'(CREDITS);

  typedef enum logic [2:0] {IDLE, WLOAD, WDRAIN, STREAM, FLUSH, DONE} state_t;

  state_t            state, state_n;
  logic [15:0]       nvec, vcnt;
  logic [WCW-1:0]    wcnt, dcnt;
  logic [3:0]        credits;
  logic [ROW*DW-1:0] act_q;
  logic [2:0]        tag_pipe [ARR_LAT];
  logic              wt_acc, act_acc, last_vec, credit_inc, flush_go, count_en;

  assign last_vec   = (vcnt == nvec - 16'd1);
  assign wt_acc     = wt_valid & wt_ready;
  assign act_acc    = act_valid & act_ready;
  assign credit_inc = res_pop && (credits != CRED_MAX);

`ifdef MAC_SEQ_SKEW_EN
  logic flush_tail;

  // After res_last the upper lanes still have ROW-1 skewed beats inside the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                flush_tail <= 1'b0;
    else if (state != FLUSH)   flush_tail <= 1'b0;
    else if (res_last)         flush_tail <= 1'b1;
  end

  assign flush_go = flush_tail && (dcnt == DLAST);
  assign count_en = (state == WDRAIN) || (flush_tail && (state == FLUSH));
`else
  assign flush_go = res_last;
  assign count_en = (state == WDRAIN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    wt_ready  = 1'b0;
    act_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = WLOAD;
      end
      WLOAD: begin
        busy     = 1'b1;
        wt_ready = 1'b1;
        if (wt_valid && (wcnt == WLAST)) state_n = WDRAIN;
      end
      WDRAIN: begin
        busy = 1'b1;
        if (dcnt == DLAST) state_n = (nvec == 16'd0) ? DONE : STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        act_ready = (credits != 4'd0);
        if (act_valid && (credits != 4'd0) && last_vec) state_n = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_go) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nvec        <= '0;
      vcnt        <= '0;
      wcnt        <= '0;
      dcnt        <= '0;
      credits     <= CRED_MAX;
      w           <= '0;
      w_en        <= '0;
      act_q       <= '0;
      mac_m_valid <= 1'b0;
      mac_m_first <= 1'b0;
      mac_m_last  <= 1'b0;
    end else begin
      w_en        <= '0;
      mac_m_valid <= 1'b0;
      mac_m_first <= 1'b0;
      mac_m_last  <= 1'b0;
      if (state == IDLE && start) begin
        nvec <= cfg_nvec;
        wcnt <= '0;
        vcnt <= '0;
      end
      if (wt_acc) begin
        w    <= wt_data;
        w_en <= '1;
        wcnt <= wcnt + 1'b1;
      end
      dcnt <= count_en ? dcnt + 1'b1 : '0;
      if (act_acc) begin
        act_q       <= act_data;
        mac_m_valid <= 1'b1;
        mac_m_first <= (vcnt == 16'd0);
        mac_m_last  <= last_vec;
        vcnt        <= vcnt + 16'd1;
      end
      // A pop against a full credit pool is spurious and dropped before netting.
      case ({credit_inc, act_acc})
        2'b10:   credits <= credits + 4'd1;
        2'b01:   credits <= credits - 4'd1;
        default: credits <= credits;
      endcase
    end
  end

  // The array cannot stall, so the tag pipe shifts every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARR_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= {mac_m_valid, mac_m_first, mac_m_last};
      for (int i = 1; i < ARR_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign {res_valid, res_first, res_last} = tag_pipe[ARR_LAT-1];

`ifdef MAC_SEQ_SKEW_EN
  for (genvar i = 0; i < ROW; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign mac_m_data[DW-1:0] = act_q[DW-1:0];
    end else begin : g_delay
      logic [DW-1:0] dly [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < i; j++) dly[j] <= '0;
        end else begin
          dly[0] <= act_q[i*DW +: DW];
          for (int j = 1; j < i; j++) dly[j] <= dly[j-1];
        end
      end
      assign mac_m_data[i*DW +: DW] = dly[i-1];
    end
  end
`else
  assign mac_m_data = act_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl (default build)
module tb_mac_seq_ctrl;
  localparam int DW = 8, WW = 8, ROW = 8, COLUMN = 6, ARR_LAT = 9, CREDITS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [15:0]          cfg_nvec = '0;
  logic                 busy, done, wt_ready, act_ready;
  logic [COLUMN*WW-1:0] wt_data = '0;
  logic                 wt_valid = 1'b0;
  logic [ROW*DW-1:0]    act_data = '0;
  logic                 act_valid = 1'b0;
  logic [COLUMN*WW-1:0] w;
  logic [COLUMN-1:0]    w_en;
  logic [ROW*DW-1:0]    mac_m_data;
  logic                 mac_m_valid, mac_m_first, mac_m_last;
  logic                 res_valid, res_first, res_last;
  logic                 res_pop = 1'b0;

  mac_seq_ctrl #(.DW(DW), .WW(WW), .ROW(ROW), .COLUMN(COLUMN), .ARR_LAT(ARR_LAT), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_nvec(cfg_nvec), .busy(busy), .done(done),
    .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
    .w(w), .w_en(w_en), .mac_m_data(mac_m_data), .mac_m_valid(mac_m_valid),
    .mac_m_first(mac_m_first), .mac_m_last(mac_m_last),
    .res_valid(res_valid), .res_first(res_first), .res_last(res_last), .res_pop(res_pop)
  );

  always #5 clk = ~clk;

  typedef struct {logic [ROW*DW-1:0] data; logic first; logic last;} act_t;
  typedef struct {int due; logic first; logic last;} res_t;

  logic [COLUMN*WW-1:0] wq[$];
  act_t aq[$];
  res_t rq[$];

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int credit_model = CREDITS;
  int held = 0;
  int expect_done = -1;
  int wbeats = 0, acc_cnt = 0, done_cnt = 0;
  int last_wt_cyc = 0;
  int pop_mode = 0;
  logic pop_manual = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Downstream buffer: pops only results it actually holds, unless forced.
  always @(posedge clk) begin
    #2;
    res_pop = pop_manual || (pop_mode == 1 && held > 0) ||
              (pop_mode == 2 && held > 0 && $urandom_range(0, 1) == 1);
  end

  always @(negedge clk) begin : monitor
    act_t ea;
    res_t er;
    logic [COLUMN*WW-1:0] ew;
    int inc, dec;
    if (!rst_n) begin
      wq.delete(); aq.delete(); rq.delete();
      credit_model = CREDITS;
      held = 0;
      expect_done = -1;
    end else begin
      if (w_en != '0) begin
        chk("w_en_value", 64'(w_en), 64'({COLUMN{1'b1}}));
        if (wq.size() == 0) chk("w_en_unexpected", 64'(1), 64'(0));
        else begin
          ew = wq.pop_front();
          chk("w_data", 64'(w), 64'(ew));
        end
        wbeats++;
      end
      dec = (act_valid && act_ready) ? 1 : 0;
      if (dec == 1) begin
        chk("credit_avail", 64'(credit_model > 0), 64'(1));
        acc_cnt++;
      end
      inc = (res_pop && credit_model < CREDITS) ? 1 : 0;
      credit_model = credit_model + inc - dec;
      if (res_pop && held > 0) held--;
      if (mac_m_valid) begin
        if (aq.size() == 0) chk("mac_m_unexpected", 64'(1), 64'(0));
        else begin
          ea = aq.pop_front();
          chk("mac_m_data", mac_m_data, ea.data);
          chk("mac_m_first", 64'(mac_m_first), 64'(ea.first));
          chk("mac_m_last", 64'(mac_m_last), 64'(ea.last));
          er.due = cyc + ARR_LAT; er.first = ea.first; er.last = ea.last;
          rq.push_back(er);
        end
      end
      if (res_valid) begin
        held++;
        if (rq.size() == 0) chk("res_unexpected", 64'(1), 64'(0));
        else begin
          er = rq.pop_front();
          chk("res_latency", 64'(cyc), 64'(er.due));
          chk("res_first", 64'(res_first), 64'(er.first));
          chk("res_last", 64'(res_last), 64'(er.last));
        end
        if (res_last) expect_done = cyc + 1;
      end
      if (done) begin
        chk("done_time", 64'(cyc), 64'(expect_done));
        chk("busy_in_done", 64'(busy), 64'(0));
        expect_done = -1;
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wt(input logic [COLUMN*WW-1:0] d);
    logic ok;
    ok = 1'b0;
    wt_data = d; wt_valid = 1'b1;
    wq.push_back(d);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (wt_ready) begin ok = 1'b1; last_wt_cyc = cyc; end
      tick();
    end
    wt_valid = 1'b0;
    chk("wt_accept", 64'(ok), 64'(1));
  endtask

  task automatic load_weights(input int wmode, input bit directed);
    logic [WW-1:0] b;
    logic [63:0]   r;
    for (int k = 0; k < ROW; k++) begin
      if (wmode == 1 && k == 4) repeat (2) tick();
      else if (wmode == 2) repeat ($urandom_range(0, 2)) tick();
      b = WW'(k + 1);
      r = {$urandom, $urandom};
      send_wt(directed ? {COLUMN{b}} : r[COLUMN*WW-1:0]);
    end
  endtask

  task automatic issue_act(input int k, input int n);
    act_t e;
    act_data = {$urandom, $urandom};
    act_valid = 1'b1;
    e.data = act_data; e.first = (k == 0); e.last = (k == n - 1);
    aq.push_back(e);
  endtask

  task automatic wait_act(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (act_ready) ok = 1'b1;
      tick();
    end
    if (ok) act_valid = 1'b0;
  endtask

  task automatic begin_tile(input int n, input int wmode, input bit directed, input bit start_busy);
    int rise;
    wbeats = 0; acc_cnt = 0; done_cnt = 0;
    cfg_nvec = 16'(n); start = 1'b1;
    tick();
    start = 1'b0;
    cfg_nvec = 16'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
    load_weights(wmode, directed);
    if (n == 0) expect_done = last_wt_cyc + ROW;
    if (start_busy) begin
      start = 1'b1; cfg_nvec = 16'd5;
      tick();
      start = 1'b0;
    end
    rise = -1;
    for (int i = 0; i < 30 && rise < 0; i++) begin
      @(negedge clk);
      if (act_ready) rise = cyc;
    end
    if (n > 0) chk("drain_to_act_ready", 64'(rise - last_wt_cyc), 64'(ROW));
    else       chk("no_act_ready_nvec0", 64'(rise), 64'(-1));
    tick();
  endtask

  task automatic finish_tile(input int n);
    logic d;
    d = (n == 0);
    for (int i = 0; i < 200 && !d; i++) begin
      @(negedge clk);
      if (done) d = 1'b1;
    end
    tick();
    chk("done_seen", 64'(d), 64'(1));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("w_beats", 64'(wbeats), 64'(ROW));
    chk("act_beats", 64'(acc_cnt), 64'(n));
    chk("queues_empty", 64'(wq.size() + aq.size() + rq.size()), 64'(0));
    chk("idle_after_tile", 64'(busy), 64'(0));
  endtask

  task automatic run_tile(input int n, input int wmode, input bit directed, input bit agap,
                          input int pmode, input bit start_busy);
    logic ok;
    pop_mode = pmode;
    begin_tile(n, wmode, directed, start_busy);
    for (int k = 0; k < n; k++) begin
      if (agap) repeat ($urandom_range(0, 2)) tick();
      issue_act(k, n);
      wait_act(200, ok);
      chk("act_accept", 64'(ok), 64'(1));
      if (!ok) begin act_valid = 1'b0; break; end
    end
    finish_tile(n);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_ctrl"}, 64'({busy, done, wt_ready, act_ready, w_en, mac_m_valid, mac_m_first,
                             mac_m_last, res_valid, res_first, res_last}), 64'(0));
    chk({name, "_w"}, 64'(w), 64'(0));
    chk({name, "_mac_data"}, mac_m_data, 64'(0));
  endtask

  initial begin
    logic ok;
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic ok;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    run_tile(3, 0, 1'b1, 1'b0, 1, 1'b0);   // directed weights 1..8, pop tied high
    run_tile(3, 1, 1'b1, 1'b0, 1, 1'b0);   // 2-cycle weight stall between beats 3 and 4
    run_tile(1, 0, 1'b0, 1'b0, 1, 1'b0);
    run_tile(0, 0, 1'b0, 1'b0, 1, 1'b0);
    run_tile(2, 0, 1'b0, 1'b0, 2, 1'b1);   // start pulsed while busy
    repeat (5) tick();
    chk("no_restart_after_done", 64'(busy), 64'(0));

    for (int t = 0; t < 20; t++)
      run_tile($urandom_range(0, 7), 2, 1'b0, 1'b1, $urandom_range(1, 2), 1'b0);

    // Abandon a tile mid-stream.
    pop_mode = 1;
    begin_tile(5, 0, 1'b0, 1'b0);
    issue_act(0, 5); wait_act(50, ok); chk("rst_pre_beat0", 64'(ok), 64'(1));
    issue_act(1, 5); wait_act(50, ok); chk("rst_pre_beat1", 64'(ok), 64'(1));
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    tick(); tick();
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (30) tick();
    chk("no_done_after_reset", 64'(done_cnt), 64'(0));
    chk("idle_after_reset", 64'(busy), 64'(0));

    // Pops against a full pool must not raise credits above CREDITS.
    pop_mode = 0;
    pop_manual = 1'b1;
    repeat (3) tick();
    pop_manual = 1'b0;
    tick();
    begin_tile(6, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      issue_act(k, 6); wait_act(20, ok);
      chk("pre_stall_accept", 64'(ok), 64'(1));
    end
    issue_act(4, 6); wait_act(20, ok);
    chk("stall_after_credits", 64'(ok), 64'(0));
    chk("accepted_at_stall", 64'(acc_cnt), 64'(CREDITS));
    pop_manual = 1'b1;
    tick();
    pop_manual = 1'b0;
    wait_act(5, ok);
    chk("one_pop_one_beat", 64'(ok), 64'(1));
    issue_act(5, 6); wait_act(20, ok);
    chk("stall_after_one_pop", 64'(ok), 64'(0));
    chk("accepted_after_pop", 64'(acc_cnt), 64'(CREDITS + 1));
    pop_mode = 1;
    wait_act(100, ok);
    chk("final_beat_accept", 64'(ok), 64'(1));
    if (!ok) act_valid = 1'b0;
    finish_tile(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
